// File: rtl/add_pkg.sv
// add_pkg: shared FSM state type and sizing helpers for the bit-serial adder
package add_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational full adder with NAND-NAND majority carry
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic n_ab, n_ac, n_bc;
  assign s    = a ^ b ^ c;
  assign n_ab = ~(a & b);
  assign n_ac = ~(a & c);
  assign n_bc = ~(b & c);
  assign co   = ~(n_ab & n_ac & n_bc);
endmodule

// File: rtl/add_serial_8bit.sv
// add_serial_8bit: LSB-first bit-serial adder with valid/ready handshakes; define ADD_OVF_EN for the signed-overflow output
module add_serial_8bit
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
`ifdef ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic c_reg, s, co;
  logic [CW-1:0] cnt;
  fa_cell u_fa (.a(sh_a[0]), .b(sh_b[0]), .c(c_reg), .s(s), .co(co));
  assign start_ready = state == IDLE;
  // accept operands, add one bit per BUSY edge, then hold the result until it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      c_reg      <= 1'b0;
      cnt        <= '0;
      sum        <= '0;
      carry      <= 1'b0;
      done_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef ADD_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          sh_a  <= a;
          sh_b  <= b;
          c_reg <= cin;
          cnt   <= '0;
          sum   <= '0;
          busy  <= 1'b1;
          state <= BUSY;
        end
        BUSY: begin
          sum   <= {s, sum[WIDTH-1:1]};
          c_reg <= co;
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            carry      <= co;
            done_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
`ifdef ADD_OVF_EN
            ovf        <= c_reg ^ co;
`endif
          end
        end
        DONE: if (done_ready) begin
          done_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_serial_8bit.sv
// tb_add_serial_8bit: scoreboard bench for the bit-serial adder (covers ovf when ADD_OVF_EN is defined)
module tb_add_serial_8bit;
  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start_valid = 1'b0, done_ready = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic start_ready, carry, done_valid, busy;
  logic [7:0] sum;
  logic ovf_obs;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;
  add_serial_8bit dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
`ifdef ADD_OVF_EN
    , .ovf(ovf_obs)
`endif
  );
`ifndef ADD_OVF_EN
  assign ovf_obs = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    e.s = t[7:0];
    e.c = t[8];
    e.o = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction
  task automatic accept(input logic [7:0] x, input logic [7:0] y, input logic ci, input bit push);
    int w;
    w = 0;
    @(negedge clk);
    while (!start_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!start_ready) chk("start_ready_timeout", 0, 1);
    a = x;
    b = y;
    cin = ci;
    start_valid = 1'b1;
    if (push) sb.push_back(model(x, y, ci));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = $urandom;
  endtask
  task automatic finish(input int hold, input bit poke);
    int cyc;
    exp_t e;
    logic [7:0] s0;
    cyc = 0;
    @(negedge clk);
    while (!done_valid && cyc < 20) begin
      if (poke && cyc == 2) begin
        start_valid = 1'b1;
        #1;
        chk("ready_in_busy", start_ready, 0);
        chk("busy_high", busy, 1);
      end else start_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0;
    chk("latency", cyc, 8);
    s0 = sum;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", done_valid, 1);
      chk("hold_sum", sum, s0);
    end
    done_ready = 1'b1;
    if (sb.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("sum", sum, e.s);
      chk("carry", carry, e.c);
`ifdef ADD_OVF_EN
      chk("ovf", ovf_obs, e.o);
`endif
    end
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    @(negedge clk);
    chk("ready_after", start_ready, 1);
    chk("valid_after", done_valid, 0);
  endtask
  initial begin
    #12;
    chk("rst_ready", start_ready, 1);
    chk("rst_valid", done_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf_obs, 0);
    rst = 1'b0;
    accept(8'h5A, 8'h25, 1'b0, 1); finish(0, 0);
    accept(8'hFF, 8'h01, 1'b0, 1); finish(0, 0);
    accept(8'h10, 8'hDF, 1'b1, 1); finish(0, 0);
    accept(8'h20, 8'hEF, 1'b1, 1); finish(0, 0);
    accept(8'h7F, 8'h01, 1'b0, 1); finish(5, 1);
    accept(8'h80, 8'h80, 1'b0, 1); finish(1, 0);
    accept(8'h33, 8'h44, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", done_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sum", sum, 0);
    chk("arst_ready", start_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    accept(8'hC3, 8'h5D, 1'b1, 1); finish(0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] x, y;
      logic ci;
      x = $urandom;
      y = $urandom;
      ci = $urandom;
      accept(x, y, ci, 1);
      finish(i % 3, 0);
    end
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
